// File: rtl/sync_filter.sv
// sync_filter: per-channel multi-flop synchronizer followed by a persistence
// (glitch) filter, with registered rise/fall pulses and sticky change flags.
//
// Build option: define SYNC_FILTER_EN to compile in the counter-based filter.
// Without it, no counters are built, FILT_CYCLES is unused, and q_filt simply
// registers q_sync every edge. Edge pulses and sticky flags behave the same
// in both builds.
//
// All state is reset synchronously by an active-high rst.

module sync_filter #(
   parameter int WIDTH       = 4,
   parameter int STAGES      = 2,
   parameter int FILT_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             evt_clr,
   output logic [WIDTH-1:0] q_sync,
   output logic [WIDTH-1:0] q_filt,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic [WIDTH-1:0] evt_sticky
);

   // Elaboration-time parameter legality checks.
   generate
      if (STAGES < 2) begin : g_bad_stages
         $error("sync_filter: STAGES must be >= 2");
      end
      if (FILT_CYCLES < 1) begin : g_bad_filt
         $error("sync_filter: FILT_CYCLES must be >= 1");
      end
   endgenerate

   // ------------------------------------------------------------------
   // Synchronizer chain
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] sync_q [STAGES];
   logic [WIDTH-1:0] sync_d [STAGES];

   // Next value of each synchronizer stage: stage 0 samples din, the rest shift.
   always_comb begin
      sync_d[0] = din;
      for (int s = 1; s < STAGES; s++) begin
         sync_d[s] = sync_q[s-1];
      end
   end

   // Synchronizer flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < STAGES; s++) begin
            sync_q[s] <= '0;
         end
      end else begin
         for (int s = 0; s < STAGES; s++) begin
            sync_q[s] <= sync_d[s];
         end
      end
   end

   logic [WIDTH-1:0] q_sync_w;
   assign q_sync_w = sync_q[STAGES-1];

   // ------------------------------------------------------------------
   // Filtered level
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] q_filt_q;
   logic [WIDTH-1:0] q_filt_d;

`ifdef SYNC_FILTER_EN
   // Each counter holds how many consecutive edges q_sync has disagreed with
   // q_filt; it only ever reaches FILT_CYCLES-1 before the level is accepted.
   localparam int CW = $clog2(FILT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

   logic [CW-1:0] cnt_q [WIDTH];
   logic [CW-1:0] cnt_d [WIDTH];

   // Persistence filter: accept a new level on the FILT_CYCLES-th consecutive
   // differing edge; any agreement in between discards the partial count.
   always_comb begin
      q_filt_d = q_filt_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (q_sync_w[i] == q_filt_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            cnt_d[i]    = '0;
            q_filt_d[i] = q_sync_w[i];
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   // Filter counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end
`else
   // Unfiltered build: q_filt is q_sync delayed by one edge.
   always_comb begin
      q_filt_d = q_sync_w;
   end
`endif

   // ------------------------------------------------------------------
   // Edge pulses and sticky flags
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] rise_q;
   logic [WIDTH-1:0] rise_d;
   logic [WIDTH-1:0] fall_q;
   logic [WIDTH-1:0] fall_d;
   logic [WIDTH-1:0] sticky_q;
   logic [WIDTH-1:0] sticky_d;

   // Pulses are decoded from the q_filt transition being registered this edge,
   // so they line up with the first cycle q_filt shows its new value. A new
   // set takes priority over a coincident clear.
   always_comb begin
      rise_d   = q_filt_d & ~q_filt_q;
      fall_d   = ~q_filt_d & q_filt_q;
      sticky_d = evt_clr ? '0 : sticky_q;
      sticky_d = sticky_d | rise_d | fall_d;
   end

   // Filtered level, pulse and sticky registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_filt_q <= '0;
         rise_q   <= '0;
         fall_q   <= '0;
         sticky_q <= '0;
      end else begin
         q_filt_q <= q_filt_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         sticky_q <= sticky_d;
      end
   end

   assign q_sync     = q_sync_w;
   assign q_filt     = q_filt_q;
   assign rise       = rise_q;
   assign fall       = fall_q;
   assign evt_sticky = sticky_q;

endmodule

// File: tb/tb_sync_filter.sv
// Testbench for sync_filter (WIDTH=4, STAGES=3, FILT_CYCLES=4).
// Works in both builds (SYNC_FILTER_EN defined or not); the reference model
// uses an effective filter length of 1 when the filter is compiled out.

module tb_sync_filter;

   localparam int WIDTH       = 4;
   localparam int STAGES      = 3;
   localparam int FILT_CYCLES = 4;
`ifdef SYNC_FILTER_EN
   localparam int FC_EFF = FILT_CYCLES;
`else
   localparam int FC_EFF = 1;
`endif
   localparam int LAT    = STAGES + FC_EFF;
   localparam int MAXE   = 4096;
   localparam int N_RAND = 2000;

   logic             clk = 1'b1;
   logic             rst = 1'b1;
   logic [WIDTH-1:0] din = '0;
   logic             evt_clr = 1'b0;
   logic [WIDTH-1:0] q_sync, q_filt, rise, fall, evt_sticky;

   sync_filter #(.WIDTH(WIDTH), .STAGES(STAGES), .FILT_CYCLES(FILT_CYCLES)) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .evt_clr    (evt_clr),
      .q_sync     (q_sync),
      .q_filt     (q_filt),
      .rise       (rise),
      .fall       (fall),
      .evt_sticky (evt_sticky)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [WIDTH-1:0] qs;
      logic [WIDTH-1:0] qf;
      logic [WIDTH-1:0] r;
      logic [WIDTH-1:0] f;
      logic [WIDTH-1:0] s;
   } exp_t;

   exp_t sb[$];

   int checks   = 0;
   int errors   = 0;
   bit drv_done = 0;

   // Per-edge history used by the reference model (index 0 = power-up, treated as reset).
   logic [WIDTH-1:0] din_a [MAXE];
   bit               rst_a [MAXE];
   bit               clr_a [MAXE];
   logic [WIDTH-1:0] qs_a  [MAXE];
   logic [WIDTH-1:0] qf_a  [MAXE];
   logic [WIDTH-1:0] st_a  [MAXE];
   int               last_chg [WIDTH];
   int               n = 0;

   task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp_v);
      end
   endtask

   // Reference model: q_sync is din from STAGES-1 edges back unless a reset
   // fell in that window; q_filt toggles when the last FC_EFF edges since the
   // previous change/reset all saw q_sync disagreeing with it.
   task automatic model_step(input int e_n);
      logic [WIDTH-1:0] qs, qf, r, f, s;
      int  lo;
      bit  any_rst;
      bit  ok;
      lo = e_n - STAGES + 1;
      any_rst = 0;
      for (int e = lo; e <= e_n; e++) begin
         if (e < 0) any_rst = 1;
         else if (rst_a[e]) any_rst = 1;
      end
      qs = any_rst ? '0 : din_a[lo];
      qs_a[e_n] = qs;
      if (rst_a[e_n]) begin
         qf = '0;
         for (int i = 0; i < WIDTH; i++) last_chg[i] = e_n;
      end else begin
         qf = qf_a[e_n-1];
         for (int i = 0; i < WIDTH; i++) begin
            ok = 1;
            for (int k = 0; k < FC_EFF; k++) begin
               if ((e_n - k) <= last_chg[i]) ok = 0;
               else if (qs_a[e_n-k-1][i] == qf_a[e_n-1][i]) ok = 0;
            end
            if (ok) begin
               qf[i] = ~qf_a[e_n-1][i];
               last_chg[i] = e_n;
            end
         end
      end
      qf_a[e_n] = qf;
      if (rst_a[e_n]) begin
         r = '0; f = '0; s = '0;
      end else begin
         r = qf & ~qf_a[e_n-1];
         f = ~qf & qf_a[e_n-1];
         s = (clr_a[e_n] ? '0 : st_a[e_n-1]) | r | f;
      end
      st_a[e_n] = s;
      sb.push_back('{qs: qs, qf: qf, r: r, f: f, s: s});
   endtask

   // Drive inputs for the next rising edge and post its expected outputs.
   task automatic drive(input logic [WIDTH-1:0] d, input logic r, input logic c);
      @(negedge clk);
      din = d; rst = r; evt_clr = c;
      n++;
      din_a[n] = d; rst_a[n] = r; clr_a[n] = c;
      model_step(n);
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   // Stimulus: directed scenarios followed by randomized traffic.
   initial begin
      logic [WIDTH-1:0] dr;
      din_a[0] = '0; rst_a[0] = 1; clr_a[0] = 0;
      qs_a[0] = '0; qf_a[0] = '0; st_a[0] = '0;
      for (int i = 0; i < WIDTH; i++) last_chg[i] = 0;

      // Reset held with all inputs high, then release.
      for (int e = 0; e < 2; e++) begin
         drive(4'hF, 1, 0);
         after_edge();
         check("reset_all_zero", {q_sync, q_filt, rise, fall, evt_sticky}, 20'h0);
      end
      for (int e = 1; e <= LAT + 1; e++) begin
         drive(4'hF, 0, 0);
         after_edge();
         if (e == STAGES - 1) check("rel_qsync_early", {16'h0, q_sync}, 20'h0);
         if (e == STAGES)     check("rel_qsync_edge", {16'h0, q_sync}, 20'hF);
         if (e == LAT - 1)    check("rel_qfilt_early", {16'h0, q_filt}, 20'h0);
         if (e == LAT)        check("rel_qfilt_rise", {12'h0, q_filt, rise}, 20'hFF);
         if (e == LAT + 1)    check("rel_rise_end_sticky", {12'h0, rise, evt_sticky}, 20'h0F);
      end
      for (int e = 0; e < 3; e++) drive(4'hF, 0, 0);

      // Clear coinciding with fall[2]: the set wins for bit 2 only.
      for (int e = 0; e < LAT; e++) begin
         drive(4'hB, 0, (e == LAT - 1));
      end
      after_edge();
      check("clr_vs_fall2", {12'h0, fall, evt_sticky}, 20'h44);
      drive(4'hB, 0, 0);
      after_edge();
      check("sticky_after_clr", {16'h0, evt_sticky}, 20'h4);

      // Settle low, short pulse on bit 0, 4-cycle pulse on bit 1.
      for (int e = 0; e < 12; e++) drive(4'h0, 0, 0);
      for (int e = 0; e < 3; e++)  drive(4'h1, 0, 0);
      for (int e = 0; e < 12; e++) drive(4'h0, 0, 0);
      for (int e = 0; e < 4; e++)  drive(4'h2, 0, 0);
      for (int e = 0; e < 14; e++) drive(4'h0, 0, (e == 13));

      // Reset in the middle of a count on bit 3, then a full-length change.
      for (int e = 0; e < STAGES + 2; e++) drive(4'h8, 0, 0);
      drive(4'h8, 1, 0);
      for (int e = 1; e <= LAT + 1; e++) begin
         drive(4'h8, 0, 0);
         after_edge();
         if (e == LAT - 1) check("midreset_qfilt3_early", {19'h0, q_filt[3]}, 20'h0);
         if (e == LAT)     check("midreset_qfilt3_rise", {18'h0, q_filt[3], rise[3]}, 20'h3);
      end

      // Randomized traffic: slowly toggling inputs, occasional clears and resets.
      dr = 4'h8;
      for (int c = 0; c < N_RAND; c++) begin
         for (int i = 0; i < WIDTH; i++) begin
            if ($urandom_range(0, 5) == 0) dr[i] = ~dr[i];
         end
         drive(dr, ($urandom_range(0, 149) == 0), ($urandom_range(0, 9) == 0));
      end
      drv_done = 1;
   end

   // Monitor: every edge the DUT presents a full output set; pop and compare.
   initial begin
      exp_t x;
      for (int k = 0; k < MAXE; k++) begin
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            if (drv_done) break;
            checks++;
            errors++;
            $display("FAIL scoreboard_empty at t=%0t: got no expectation, expected one", $time);
         end else begin
            x = sb.pop_front();
            check("q_sync",     {16'h0, q_sync},     {16'h0, x.qs});
            check("q_filt",     {16'h0, q_filt},     {16'h0, x.qf});
            check("rise",       {16'h0, rise},       {16'h0, x.r});
            check("fall",       {16'h0, fall},       {16'h0, x.f});
            check("evt_sticky", {16'h0, evt_sticky}, {16'h0, x.s});
            checks++;
            if ((rise & fall) != '0) begin
               errors++;
               $display("FAIL rise_fall_overlap at t=%0t: got %h expected 0", $time, rise & fall);
            end
         end
      end
      if (!drv_done || sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL monitor_budget at t=%0t: got %0d pending expected 0", $time, sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog against a stalled run.
   initial begin
      #(MAXE * 10 * 2);
      $display("FAIL watchdog at t=%0t: got timeout expected completion", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sync_filter.md
SYNC_FILTER -- requirements
Module: sync_filter

Interface
REQ-001 Parameter WIDTH, default 4: number of independent single-bit channels.
REQ-002 Parameter STAGES, default 2: synchronizer flop depth per channel; legal range >= 2.
REQ-003 Parameter FILT_CYCLES, default 4: consecutive edges a changed level must persist before acceptance; legal range >= 1.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 din  input  WIDTH  asynchronous channel inputs.
REQ-007 evt_clr  input  1  single-cycle pulse; clears all evt_sticky bits.
REQ-008 q_sync  output  WIDTH  raw synchronized level, last flop of each chain.
REQ-009 q_filt  output  WIDTH  glitch-filtered level, registered.
REQ-010 rise  output  WIDTH  one-cycle pulse per bit when q_filt goes 0->1, registered.
REQ-011 fall  output  WIDTH  one-cycle pulse per bit when q_filt goes 1->0, registered.
REQ-012 evt_sticky  output  WIDTH  per-bit latched flag of any q_filt change since last clear.

Function
REQ-013 Each din bit shall pass through a STAGES-deep flop chain; q_sync[i] equals din[i] as sampled STAGES edges earlier.
REQ-014 The filter shall keep one counter per bit of width $clog2(FILT_CYCLES+1), plus q_filt[i].
REQ-015 Per edge, when q_sync[i]==q_filt[i]: counter[i] <= 0 and q_filt[i] holds.
REQ-016 Per edge, when q_sync[i]!=q_filt[i] and counter[i]<FILT_CYCLES-1: counter[i] increments and q_filt[i] holds.
REQ-017 Per edge, when q_sync[i]!=q_filt[i] and counter[i]==FILT_CYCLES-1: q_filt[i] <= q_sync[i] and counter[i] <= 0.
REQ-018 q_filt[i] shall therefore change only on the FILT_CYCLES-th consecutive edge at which q_sync[i] differs; any return to equality before that discards the count.
REQ-019 With FILT_CYCLES=1, q_filt[i] shall follow q_sync[i] with one edge of delay.
REQ-020 The minimum din-to-q_filt latency for a stable change shall be STAGES+FILT_CYCLES edges.
REQ-021 rise[i] and fall[i] shall be high for exactly the one cycle in which q_filt[i] holds its new value; rise and fall for the same bit shall never be high together.
REQ-022 evt_sticky[i] shall set on the edge at which rise[i] or fall[i] is asserted, and hold until cleared.
REQ-023 evt_clr shall clear all evt_sticky bits on the next edge.
REQ-024 If evt_clr coincides with a new set for bit i, the set shall win and evt_sticky[i] shall be 1.
REQ-025 Channels shall be fully independent; activity on one bit shall not affect any other bit's counter or outputs.

Reset
REQ-026 While rst is high at a clock edge, every sync flop, counter, q_sync, q_filt, rise, fall and evt_sticky bit shall be 0.
REQ-027 Reset mid-count shall discard any partial count; after release a change requires the full FILT_CYCLES again.
REQ-028 If din is held 1 through reset release, q_filt shall rise after STAGES+FILT_CYCLES edges and produce rise and evt_sticky like any other change.

Configuration
REQ-029 Macro SYNC_FILTER_EN, when defined, shall compile in the counter-based filter of REQ-014..REQ-019.
REQ-030 When SYNC_FILTER_EN is undefined, no counters shall be built, FILT_CYCLES shall be ignored, and q_filt[i] shall register q_sync[i] every edge; REQ-021..REQ-024 remain in force.

Verification (WIDTH=4, STAGES=3, FILT_CYCLES=4, macro defined unless stated)
REQ-031 rst=1 for 2 cycles with din=4'hF -> all outputs 0 during reset; after release q_sync=4'hF at edge 3, q_filt=4'hF and rise=4'hF at edge 7 for one cycle, evt_sticky=4'hF thereafter.
REQ-032 From settled 0, din[0] high for 3 cycles -> q_sync[0] shows a 3-cycle pulse; q_filt, rise and evt_sticky stay 0.
REQ-033 din[1] high for 4 cycles, then low -> q_filt[1] rises 7 edges after din rises and falls 4 edges after q_sync[1] falls; one rise and one fall pulse; evt_sticky[1]=1.
REQ-034 evt_sticky=4'hF; evt_clr pulsed on the same edge fall[2] asserts -> evt_sticky=4'b0100 afterwards.
REQ-035 rst asserted after 2 differing edges on bit 3 -> counter and q_filt cleared; after release with din[3]=1 the change takes the full 3+4 edges.
REQ-036 Macro undefined: 1-cycle high at q_sync[0] -> q_filt[0] high for 1 cycle one edge later; rise[0] then fall[0] on consecutive cycles.
